// File: rtl/encoder_bcd.sv
// encoder_bcd: two-digit BCD to 7-bit binary converter using reverse
// double-dabble, one shift/correct step per clock, seven steps per result.
// Optional macro ENCODER_BCD_CHECK_EN flags digits above 9 on err and
// forces out to zero for such conversions; without it err is tied low.
module encoder_bcd (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in1,
    input  logic [3:0] in0,
    input  logic       start,
    output logic [6:0] out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  bcd;
    logic [6:0]  bin;
    logic [2:0]  cnt;
    logic [14:0] shifted;
    logic [7:0]  step_bcd;
    logic [6:0]  step_bin;
    logic        accept;
    logic        last;

    // A new conversion is accepted from IDLE or DONE; start is ignored in SHIFT
    assign accept = start && (state != SHIFT);
    assign last   = (cnt == 3'd6);

    // One reverse double-dabble step: shift right, then subtract 3 from nibbles >= 8
    always_comb begin
        shifted  = {bcd, bin} >> 1;
        step_bcd = shifted[14:7];
        step_bin = shifted[6:0];
        if (shifted[14:11] >= 4'd8) begin
            step_bcd[7:4] = shifted[14:11] - 4'd3;
        end
        if (shifted[10:7] >= 4'd8) begin
            step_bcd[3:0] = shifted[10:7] - 4'd3;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? SHIFT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef ENCODER_BCD_CHECK_EN
    logic invalid;
    logic err_q;

    assign err = err_q;

    // Datapath with digit checking: invalid digits recorded at accept, reported at the end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd     <= '0;
            bin     <= '0;
            cnt     <= '0;
            out     <= '0;
            invalid <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            bcd     <= {in1, in0};
            bin     <= '0;
            cnt     <= '0;
            invalid <= (in1 > 4'd9) || (in0 > 4'd9);
            err_q   <= 1'b0;
        end else if (state == SHIFT) begin
            bcd <= step_bcd;
            bin <= step_bin;
            cnt <= cnt + 3'd1;
            if (last) begin
                out   <= invalid ? '0 : step_bin;
                err_q <= invalid;
            end
        end
    end
`else
    assign err = 1'b0;

    // Datapath: load digits at accept, step each SHIFT cycle, publish result on the last step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd <= '0;
            bin <= '0;
            cnt <= '0;
            out <= '0;
        end else if (accept) begin
            bcd <= {in1, in0};
            bin <= '0;
            cnt <= '0;
        end else if (state == SHIFT) begin
            bcd <= step_bcd;
            bin <= step_bin;
            cnt <= cnt + 3'd1;
            if (last) begin
                out <= step_bin;
            end
        end
    end
`endif

endmodule

// File: tb/tb_encoder_bcd.sv
// tb_encoder_bcd: table vectors, hand sequences for reset/abort and start
// noise, exhaustive valid sweep and random nibbles against a digit model.
module tb_encoder_bcd;

    logic       clk;
    logic       rst_n;
    logic [3:0] in1;
    logic [3:0] in0;
    logic       start;
    logic [6:0] out;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [3:0] t;
        logic [3:0] u;
        logic       noise;
        int         exp_out;
        int         exp_err;
    } vec_t;

    vec_t vecs[8];

    encoder_bcd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in1),
        .in0   (in0),
        .start (start),
        .out   (out),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected result from the digits: decimal value for valid digits,
    // otherwise the plain shift/correct recurrence on the digit values.
    task automatic model(input int t, input int u, output int o, output int e);
        int hi;
        int lo;
        int b;
        e = 0;
`ifdef ENCODER_BCD_CHECK_EN
        if (t > 9 || u > 9) begin
            o = 0;
            e = 1;
            return;
        end
`endif
        if (t <= 9 && u <= 9) begin
            o = 10 * t + u;
        end else begin
            hi = t;
            lo = u;
            b  = 0;
            for (int i = 0; i < 7; i++) begin
                b  = b / 2 + (lo % 2) * 64;
                lo = lo / 2 + (hi % 2) * 8;
                hi = hi / 2;
                if (hi >= 8) hi -= 3;
                if (lo >= 8) lo -= 3;
            end
            o = b;
        end
    endtask

    // Called at a negedge with the DUT in IDLE or DONE; returns at the
    // negedge of the DONE cycle with start released.
    task automatic convert(input logic [3:0] t, input logic [3:0] u, input logic noise,
                           input int eo, input int ee);
        in1   = t;
        in0   = u;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in1   = 4'($urandom);
        in0   = 4'($urandom);
        check("busy_first", int'(busy), 1);
        check("done_first", int'(done), 0);
        for (int k = 0; k < 6; k++) begin
            if (noise) begin
                start = 1'($urandom);
                in1   = 4'($urandom);
                in0   = 4'($urandom);
            end
            @(negedge clk);
            check("busy_shift", int'(busy), 1);
            check("done_shift", int'(done), 0);
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", int'(done), 1);
        check("busy_done", int'(busy), 0);
        check("out", int'(out), eo);
        check("err", int'(err), ee);
    endtask

    initial begin
        int eo;
        int ee;
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{4'd0,  4'd0, 1'b0, 0,  0};
        vecs[1] = '{4'd9,  4'd9, 1'b0, 99, 0};
        vecs[2] = '{4'd4,  4'd2, 1'b1, 42, 0};
        vecs[3] = '{4'd1,  4'd0, 1'b0, 10, 0};
        vecs[4] = '{4'd2,  4'd5, 1'b1, 25, 0};
        vecs[5] = '{4'd0,  4'd9, 1'b0, 9,  0};
        vecs[6] = '{4'd9,  4'd0, 1'b0, 90, 0};
`ifdef ENCODER_BCD_CHECK_EN
        vecs[7] = '{4'd12, 4'd3, 1'b0, 0,  1};
`else
        vecs[7] = '{4'd12, 4'd3, 1'b0, 123, 0};
`endif

        // Reset with start held high: start must be ignored
        rst_n = 1'b0;
        start = 1'b1;
        in1   = 4'd7;
        in0   = 4'd7;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_out", int'(out), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);

        // Table vectors, back to back
        foreach (vecs[i]) begin
            convert(vecs[i].t, vecs[i].u, vecs[i].noise, vecs[i].exp_out, vecs[i].exp_err);
        end

        // DONE without start returns to IDLE; out and err are held
        @(negedge clk);
        check("post_done", int'(done), 0);
        check("post_busy", int'(busy), 0);
        check("hold_out", int'(out), vecs[7].exp_out);
        check("hold_err", int'(err), vecs[7].exp_err);
        repeat (2) @(negedge clk);
        check("hold_out2", int'(out), vecs[7].exp_out);

        // err clears on the next accepted start
        convert(4'd2, 4'd5, 1'b0, 25, 0);
        @(negedge clk);

        // Reset in the middle of a conversion, start asserted alongside
        in1   = 4'd5;
        in0   = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_out", int'(out), 0);
        check("abort_err", int'(err), 0);
        rst_n = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("abort_no_done", int'(done), 0);
            check("abort_no_busy", int'(busy), 0);
        end
        convert(4'd1, 4'd0, 1'b0, 10, 0);

        // Exhaustive valid sweep, back to back
        for (int t = 0; t < 10; t++) begin
            for (int u = 0; u < 10; u++) begin
                model(t, u, eo, ee);
                convert(4'(t), 4'(u), 1'b0, eo, ee);
            end
        end

        // Random nibbles over the full 0..15 range, with start noise
        for (int r = 0; r < 40; r++) begin
            int t;
            int u;
            t = int'($urandom_range(15, 0));
            u = int'($urandom_range(15, 0));
            model(t, u, eo, ee);
            convert(4'(t), 4'(u), 1'($urandom), eo, ee);
            if ($urandom_range(1, 0) == 0) begin
                @(negedge clk);
                check("rand_idle_done", int'(done), 0);
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/encoder_bcd.md
ENCODER_BCD -- requirements
Module: encoder_bcd

Interface
REQ-001 The block SHALL expose: clk  input  1  single rising-edge clock for all state.
REQ-002 The block SHALL expose: rst_n  input  1  reset, synchronous, active-low.
REQ-003 The block SHALL expose: in1  input  4  BCD tens digit.
REQ-004 The block SHALL expose: in0  input  4  BCD units digit.
REQ-005 The block SHALL expose: start  input  1  conversion request, sampled on clk rising edge.
REQ-006 The block SHALL expose: out  output  7  binary result, 0..99.
REQ-007 The block SHALL expose: busy  output  1  high while a conversion is in progress.
REQ-008 The block SHALL expose: done  output  1  one-cycle pulse, out valid.
REQ-009 The block SHALL expose: err  output  1  invalid-digit flag, valid with done.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-011 IDLE or DONE with start=1 at edge N SHALL latch {in1,in0} into an 8-bit BCD register, clear a 7-bit binary register and a 3-bit iteration counter, and enter SHIFT.
REQ-012 The algorithm SHALL be reverse double-dabble: each SHIFT cycle shifts the 15-bit {bcd,bin} right by one, then subtracts 3 from each BCD nibble that is >= 8.
REQ-013 SHIFT SHALL perform exactly 7 iterations, at edges N+1..N+7; the transition to DONE SHALL occur at edge N+7.
REQ-014 out SHALL be loaded from the binary register at edge N+7 and held until the next accepted start or reset.
REQ-015 done SHALL be high only during the cycle in DONE (after edge N+7, before edge N+8).
REQ-016 busy SHALL be high exactly while in SHIFT.
REQ-017 start while in SHIFT SHALL be ignored, with no effect on the conversion in progress.
REQ-018 DONE without start SHALL return to IDLE at the next edge; DONE with start SHALL begin a new conversion with no idle gap.
REQ-019 in1/in0 changes after edge N SHALL NOT affect the current result.
REQ-020 For valid digits, out SHALL equal 10*in1 + in0 (max 99 = 7'b1100011).

Reset
REQ-021 rst_n=0 at any rising edge, including mid-SHIFT, SHALL force IDLE, out=0, busy=0, done=0, err=0, and clear the BCD register, binary register and counter.
REQ-022 start sampled in the same cycle as rst_n=0 SHALL be ignored.
REQ-023 After release, the first conversion SHALL behave as in REQ-011..REQ-020.

Configuration
REQ-024 Macro ENCODER_BCD_CHECK_EN defined: at accept, in1>9 or in0>9 SHALL be recorded; timing per REQ-013..REQ-015 is unchanged; at edge N+7, err=1 and out=0.
REQ-025 Macro ENCODER_BCD_CHECK_EN defined: err SHALL reset to 0 at the next accepted start.
REQ-026 Macro ENCODER_BCD_CHECK_EN undefined: err SHALL be constant 0, and for nibbles >9 out SHALL be the algorithm result of REQ-012 (no checking).

Verification
REQ-027 Reset, then in1=0, in0=0, start pulse -> done at edge N+7, out=0, err=0.
REQ-028 in1=9, in0=9, start at edge N -> busy high edges N..N+7, done one cycle, out=7'b1100011 (99).
REQ-029 Exhaustive sweep of all 100 valid pairs, back-to-back start on each done -> out=10*in1+in0 for every pair, with no idle cycles between conversions.
REQ-030 in1=4, in0=2 start; start pulsed again and inputs changed to 7,7 at edge N+3 -> out=42, single done pulse.
REQ-031 in1=5, in0=5 start; rst_n=0 at edge N+4 -> busy=0, done never asserted, out=0; next 1,0 conversion -> out=10.
REQ-032 With ENCODER_BCD_CHECK_EN defined: in1=12, in0=3 -> done at N+7, err=1, out=0; next 2,5 -> err=0, out=25.
